execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage RISC-V pipeline, directly upstream of the memory-access stage; drives the complete EX/MEM pipeline register that stage consumes.
- Performs operand forwarding from EX/MEM and MEM/WB, a single-cycle ALU, and an iterative 32-cycle multiply/divide unit.
- Holds the pipeline through `ex_stall` while the multiply/divide unit is busy.

Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `RA_W`, 5, register address width.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `ID_EX_valid` in 1: instruction present in ID/EX.
- `ID_EX_alu_ctrl` in 5: operation code, see Behaviour.
- `ID_EX_alu_src` in 1: 1 = operand B is `ID_EX_imm`.
- `ID_EX_dataA` in 32: rs1 register-file value.
- `ID_EX_dataB` in 32: rs2 register-file value.
- `ID_EX_imm` in 32: sign-extended immediate.
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd` in 5 each: register addresses.
- `ID_EX_reg_write`, `ID_EX_mem_to_reg`, `ID_EX_mem_read`, `ID_EX_mem_write` in 1 each: control bits.
- `MEM_WB_reg_write` in 1: write-back enable.
- `MEM_WB_rd` in 5: write-back destination.
- `wb_data` in 32: write-back result (mux output).
- `ex_stall` out 1: hold IF/ID/ID_EX; combinational.
- `EX_MEM_mem_to_reg`, `EX_MEM_reg_write`, `EX_MEM_mem_read`, `EX_MEM_mem_write` out 1 each: registered control bits.
- `EX_MEM_alu_out` out 32: result, also the memory address.
- `EX_MEM_dataB` out 32: forwarded rs2 value (store data).
- `EX_MEM_rd` out 5: destination register.

Behaviour:
- Clock and reset: single clock `clk`. `reset_n` is asynchronous and active-low.
- Reset values: all `EX_MEM_*` outputs are 0. The multiply/divide FSM goes to IDLE, its counter to 0, and `ex_stall` reads 0.
- Reset mid-operation: reset asserted during BUSY aborts the operation, with no partial write.

Forwarding (rs1 and rs2 independently, combinational):
- If `EX_MEM_reg_write`, `EX_MEM_rd` != 0 and `EX_MEM_rd` == rs, use the registered `EX_MEM_alu_out`.
- Otherwise, if `MEM_WB_reg_write`, `MEM_WB_rd` != 0 and `MEM_WB_rd` == rs, use `wb_data`.
- Otherwise use the ID_EX value.
- EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Load-use hazards are stalled by the hazard unit, not here.

Operand B and store data:
- `opB` = `ID_EX_alu_src` ? `imm` : forwarded rs2.
- `EX_MEM_dataB` always carries forwarded rs2.

ALU ops, single cycle, result registered at the next edge:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 SRA; shift amount is `opB[4:0]`.
- 8 SLT (signed), 9 SLTU; result is 0 or 1.
- 10 PASSB.
- 11–15 give result 0.
- Arithmetic wraps modulo 2^32.

Multiply/divide ops (`alu_ctrl[4]`=1):
- 16 MUL: low 32 bits of the product.
- 17 MULHU: high 32 bits, unsigned.
- 18 DIV, 19 DIVU.
- 20 REM, 21 REMU.
- 22–31 give result 0, with the same latency.

Multiply/divide FSM (IDLE, BUSY, DONE):
- IDLE: on `ID_EX_valid` with a multiply/divide op, capture the forwarded operands and `opcode`, go to BUSY with count=0. `ex_stall`=1 this cycle.
- BUSY: one shift-add or restoring-divide step per cycle on magnitudes, with sign fix-up at the end. At count==31 go to DONE. `ex_stall`=1.
- DONE: result is valid, `ex_stall`=0, and EX/MEM loads the result plus the ID_EX control bits at this edge. Return to IDLE.
- Total: `ex_stall` high for exactly 33 consecutive cycles. The result appears in `EX_MEM_alu_out` 34 edges after issue. The latency is fixed and independent of operand values.
- Divide by zero: quotient is 0xFFFFFFFF; remainder equals the dividend.
- DIV overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000, remainder is 0.
- REM sign follows the dividend.

While `ex_stall`=1:
- EX/MEM captures a bubble: `reg_write`, `mem_read`, `mem_write` and `mem_to_reg` are 0; `rd`, `alu_out` and `dataB` hold their values.
- ID_EX inputs are held stable by upstream. Operands are taken only at issue, so later forwarding changes are ignored.

Bubbles:
- `ID_EX_valid`=0 writes a bubble (all control bits 0) into EX/MEM.
- A multiply/divide op never starts without valid.

Back-to-back multiply/divide ops:
- The second op is issued from IDLE on the cycle after DONE, giving another 33-cycle stall.

Test Plan:
- Reset: assert `reset_n`=0 mid-run, including during BUSY → all `EX_MEM_*` outputs are 0 and `ex_stall`=0 immediately. After release, ADD 5+7 → `EX_MEM_alu_out`=12 one edge later.
- Forwarding priority: `EX_MEM_rd`=3 with `alu_out`=0x11 and `MEM_WB_rd`=3 with `wb_data`=0x22; ADD rs1=3, rs2=0 → result 0x11. Repeat with `EX_MEM_reg_write`=0 → 0x22. Repeat with rd=0 on both → ID_EX value used.
- Shifts/compares: SRA 0x80000000 by 4 → 0xF8000000; SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0; SUB 0 − 1 → 0xFFFFFFFF.
- MUL/MULHU: 0xFFFFFFFF × 0xFFFFFFFF → MUL 0x00000001, MULHU 0xFFFFFFFE. Check `ex_stall` high for 33 cycles, bubbles in EX/MEM during the stall, and the result with `reg_write`=1 after.
- Division corners: DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; DIVU 10/0 → 0xFFFFFFFF, REMU 10/0 → 10; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Store path: SW with `alu_src`=1, imm=8, rs1=0x100, rs2 forwarded from MEM/WB as 0xDEADBEEF → `EX_MEM_alu_out`=0x108, `EX_MEM_dataB`=0xDEADBEEF, `mem_write`=1.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, single-cycle ALU, iterative 32-step mul/div
// unit and the EX/MEM pipeline register feeding the memory-access stage.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no mul/div in flight; a valid mul/div op issues from here
// BUSY  | one shift-add / restoring-divide step per cycle (32 steps)
// DONE  | result ready; EX/MEM loads it this edge, back to IDLE
module execute_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ID_EX_valid,
    input  logic [4:0]      ID_EX_alu_ctrl,
    input  logic            ID_EX_alu_src,
    input  logic [XLEN-1:0] ID_EX_dataA,
    input  logic [XLEN-1:0] ID_EX_dataB,
    input  logic [XLEN-1:0] ID_EX_imm,
    input  logic [RA_W-1:0] ID_EX_rs1,
    input  logic [RA_W-1:0] ID_EX_rs2,
    input  logic [RA_W-1:0] ID_EX_rd,
    input  logic            ID_EX_reg_write,
    input  logic            ID_EX_mem_to_reg,
    input  logic            ID_EX_mem_read,
    input  logic            ID_EX_mem_write,
    input  logic            MEM_WB_reg_write,
    input  logic [RA_W-1:0] MEM_WB_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_stall,
    output logic            EX_MEM_mem_to_reg,
    output logic            EX_MEM_reg_write,
    output logic            EX_MEM_mem_read,
    output logic            EX_MEM_mem_write,
    output logic [XLEN-1:0] EX_MEM_alu_out,
    output logic [XLEN-1:0] EX_MEM_dataB,
    output logic [RA_W-1:0] EX_MEM_rd
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    logic [4:0]      r_count;
    logic [4:0]      r_op;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            r_mem_to_reg, r_reg_write, r_mem_read, r_mem_write;
    logic [XLEN-1:0] r_alu_out, r_dataB;
    logic [RA_W-1:0] r_rd;

    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_opb, w_alu_result, w_md_result;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_diff;
    logic [XLEN:0]   w_sum, w_shift;
    logic            w_md_issue, w_issue_div, w_issue_signed, w_ge;

    // x0 never forwards; the newer EX/MEM result wins over MEM/WB
    assign w_fwd_a = (r_reg_write && r_rd != '0 && r_rd == ID_EX_rs1) ? r_alu_out :
                     (MEM_WB_reg_write && MEM_WB_rd != '0 && MEM_WB_rd == ID_EX_rs1) ? wb_data :
                     ID_EX_dataA;
    assign w_fwd_b = (r_reg_write && r_rd != '0 && r_rd == ID_EX_rs2) ? r_alu_out :
                     (MEM_WB_reg_write && MEM_WB_rd != '0 && MEM_WB_rd == ID_EX_rs2) ? wb_data :
                     ID_EX_dataB;
    assign w_opb   = ID_EX_alu_src ? ID_EX_imm : w_fwd_b;

    assign w_md_issue     = (r_state == S_IDLE) && ID_EX_valid && ID_EX_alu_ctrl[4];
    // reset must read as "no stall" even while upstream still presents a mul/div op
    assign ex_stall       = reset_n && (w_md_issue || (r_state == S_BUSY));
    assign w_issue_div    = (ID_EX_alu_ctrl >= 5'd18) && (ID_EX_alu_ctrl <= 5'd21);
    assign w_issue_signed = (ID_EX_alu_ctrl == 5'd18) || (ID_EX_alu_ctrl == 5'd20);
    assign w_abs_a = (w_issue_signed && w_fwd_a[XLEN-1]) ? -w_fwd_a : w_fwd_a;
    assign w_abs_b = (w_issue_signed && w_fwd_b[XLEN-1]) ? -w_fwd_b : w_fwd_b;

    // one multiply step: conditional add, then shift {hi,lo} right
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    // one restoring divide step: shift in next dividend bit, trial subtract
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_mcand};
    assign w_diff  = w_shift[XLEN-1:0] - r_mcand;

    // single-cycle ALU
    always_comb begin
        w_alu_result = '0;
        case (ID_EX_alu_ctrl)
            5'd0:    w_alu_result = w_fwd_a + w_opb;
            5'd1:    w_alu_result = w_fwd_a - w_opb;
            5'd2:    w_alu_result = w_fwd_a & w_opb;
            5'd3:    w_alu_result = w_fwd_a | w_opb;
            5'd4:    w_alu_result = w_fwd_a ^ w_opb;
            5'd5:    w_alu_result = w_fwd_a << w_opb[4:0];
            5'd6:    w_alu_result = w_fwd_a >> w_opb[4:0];
            5'd7:    w_alu_result = $signed(w_fwd_a) >>> w_opb[4:0];
            5'd8:    w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_fwd_a) < $signed(w_opb)};
            5'd9:    w_alu_result = {{(XLEN-1){1'b0}}, w_fwd_a < w_opb};
            5'd10:   w_alu_result = w_opb;
            default: w_alu_result = '0;
        endcase
    end

    // final mul/div result with sign and divide-by-zero fix-up
    always_comb begin
        w_md_result = '0;
        case (r_op)
            5'd16:   w_md_result = r_lo;
            5'd17:   w_md_result = r_hi;
            5'd18:   w_md_result = r_div_zero ? '1 : (r_neg_q ? -r_lo : r_lo);
            5'd19:   w_md_result = r_div_zero ? '1 : r_lo;
            5'd20:   w_md_result = r_div_zero ? r_dividend : (r_neg_r ? -r_hi : r_hi);
            5'd21:   w_md_result = r_hi;
            default: w_md_result = '0;
        endcase
    end

    // mul/div sequencer and iterative datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
            r_mcand    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_issue) begin
                        r_state    <= S_BUSY;
                        r_count    <= '0;
                        r_op       <= ID_EX_alu_ctrl;
                        r_is_div   <= w_issue_div;
                        r_neg_q    <= w_issue_signed && (w_fwd_a[XLEN-1] ^ w_fwd_b[XLEN-1]);
                        r_neg_r    <= w_issue_signed && w_fwd_a[XLEN-1];
                        r_div_zero <= (w_fwd_b == '0);
                        r_dividend <= w_fwd_a;
                        r_mcand    <= w_issue_div ? w_abs_b : w_fwd_b;
                        r_lo       <= w_issue_div ? w_abs_a : w_fwd_a;
                        r_hi       <= '0;
                    end
                end
                S_BUSY: begin
                    if (r_is_div) begin
                        r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    if (r_count == 5'd31) begin
                        r_state <= S_DONE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM register: bubble while stalled, mul/div result on DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_out    <= '0;
            r_dataB      <= '0;
            r_rd         <= '0;
        end else if (ex_stall) begin
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_alu_out    <= (r_state == S_DONE) ? w_md_result : w_alu_result;
            r_dataB      <= w_fwd_b;
            r_rd         <= ID_EX_rd;
            r_mem_to_reg <= ID_EX_valid && ID_EX_mem_to_reg;
            r_reg_write  <= ID_EX_valid && ID_EX_reg_write;
            r_mem_read   <= ID_EX_valid && ID_EX_mem_read;
            r_mem_write  <= ID_EX_valid && ID_EX_mem_write;
        end
    end

    assign EX_MEM_mem_to_reg = r_mem_to_reg;
    assign EX_MEM_reg_write  = r_reg_write;
    assign EX_MEM_mem_read   = r_mem_read;
    assign EX_MEM_mem_write  = r_mem_write;
    assign EX_MEM_alu_out    = r_alu_out;
    assign EX_MEM_dataB      = r_dataB;
    assign EX_MEM_rd         = r_rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU, store path, mul/div
// latency and corner cases, bubbles and reset behaviour.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ID_EX_valid = 1'b0;
    logic [4:0]  ID_EX_alu_ctrl = '0;
    logic        ID_EX_alu_src = 1'b0;
    logic [31:0] ID_EX_dataA = '0, ID_EX_dataB = '0, ID_EX_imm = '0;
    logic [4:0]  ID_EX_rs1 = '0, ID_EX_rs2 = '0, ID_EX_rd = '0;
    logic        ID_EX_reg_write = 1'b0, ID_EX_mem_to_reg = 1'b0;
    logic        ID_EX_mem_read = 1'b0, ID_EX_mem_write = 1'b0;
    logic        MEM_WB_reg_write = 1'b0;
    logic [4:0]  MEM_WB_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_stall;
    logic        EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write;
    logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
    logic [4:0]  EX_MEM_rd;

    int checks = 0;
    int errors = 0;

    execute_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .ID_EX_valid(ID_EX_valid), .ID_EX_alu_ctrl(ID_EX_alu_ctrl),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_dataA(ID_EX_dataA),
        .ID_EX_dataB(ID_EX_dataB), .ID_EX_imm(ID_EX_imm),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_rd(MEM_WB_rd), .wb_data(wb_data),
        .ex_stall(ex_stall),
        .EX_MEM_mem_to_reg(EX_MEM_mem_to_reg), .EX_MEM_reg_write(EX_MEM_reg_write),
        .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB), .EX_MEM_rd(EX_MEM_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mr, input logic mw);
        ID_EX_valid      = 1'b1;
        ID_EX_alu_ctrl   = op;
        ID_EX_dataA      = a;
        ID_EX_dataB      = b;
        ID_EX_imm        = imm;
        ID_EX_alu_src    = src;
        ID_EX_rs1        = rs1;
        ID_EX_rs2        = rs2;
        ID_EX_rd         = rd;
        ID_EX_reg_write  = rw;
        ID_EX_mem_to_reg = m2r;
        ID_EX_mem_read   = mr;
        ID_EX_mem_write  = mw;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write} !== 4'b0 ||
            EX_MEM_alu_out !== 32'h0 || EX_MEM_dataB !== 32'h0 || EX_MEM_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: alu_out=%h dataB=%h rd=%0d", EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_rd);
        end
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", ex_stall);
        end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        drive(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'd12 || EX_MEM_reg_write !== 1'b1 || EX_MEM_rd !== 5'd1) begin
            errors++;
            $display("FAIL reset_add: got %h rw=%b want 0000000c rw=1", EX_MEM_alu_out, EX_MEM_reg_write);
        end
    endtask

    task automatic test_forwarding();
        MEM_WB_reg_write = 1'b1;
        MEM_WB_rd = 5'd3;
        wb_data = 32'h22;
        drive(5'd0, 32'h11, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'h11) begin
            errors++;
            $display("FAIL fwd_exmem_priority: got %h want 00000011", EX_MEM_alu_out);
        end
        drive(5'd0, 32'h11, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'h22) begin
            errors++;
            $display("FAIL fwd_memwb: got %h want 00000022", EX_MEM_alu_out);
        end
        MEM_WB_rd = 5'd0;
        drive(5'd0, 32'h11, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'h99) begin
            errors++;
            $display("FAIL fwd_x0: got %h want 00000099", EX_MEM_alu_out);
        end
        // rs2 forwarded from EX/MEM (rd=4, 0x99) into both opB and store data
        drive(5'd0, 32'h1, 32'h5, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'h9a || EX_MEM_dataB !== 32'h99) begin
            errors++;
            $display("FAIL fwd_rs2: got %h/%h want 0000009a/00000099", EX_MEM_alu_out, EX_MEM_dataB);
        end
        MEM_WB_reg_write = 1'b0;
    endtask

    task automatic test_alu();
        logic [4:0]  ops [12];
        logic [31:0] av  [12];
        logic [31:0] bv  [12];
        logic [31:0] ev  [12];
        logic        src [12];
        ops = '{5'd7, 5'd8, 5'd9, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd12, 5'd0};
        av  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hF0F0, 32'hF0F0, 32'hF0F0,
                32'h1, 32'h80000000, 32'h0, 32'h1234, 32'hFFFFFFFF};
        bv  = '{32'h4, 32'h1, 32'h1, 32'h1, 32'hFF00, 32'hFF00, 32'hFF00,
                32'h23, 32'd31, 32'h1234, 32'h1, 32'h2};
        ev  = '{32'hF8000000, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hF000, 32'hFFF0, 32'h0FF0,
                32'h8, 32'h1, 32'h1234, 32'h0, 32'h1};
        src = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], av[i], src[i] ? 32'h0 : bv[i], src[i] ? bv[i] : 32'h0, src[i],
                  5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (EX_MEM_alu_out !== ev[i]) begin
                errors++;
                $display("FAIL alu_op%0d: got %h want %h", ops[i], EX_MEM_alu_out, ev[i]);
            end
        end
    endtask

    task automatic test_store();
        MEM_WB_reg_write = 1'b1;
        MEM_WB_rd = 5'd9;
        wb_data = 32'hDEADBEEF;
        drive(5'd0, 32'h100, 32'h5555, 32'h8, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'h108 || EX_MEM_dataB !== 32'hDEADBEEF ||
            EX_MEM_mem_write !== 1'b1 || EX_MEM_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL store: addr=%h data=%h mw=%b want 00000108 deadbeef 1",
                     EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_mem_write);
        end
        MEM_WB_reg_write = 1'b0;
        MEM_WB_rd = 5'd0;
    endtask

    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int n;
        int edges;
        logic [4:0] rd_before;
        rd_before = EX_MEM_rd;
        drive(op, a, b, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n = ex_stall ? 1 : 0;
        edges = 0;
        while (ex_stall && edges < 100) begin
            tick();
            edges++;
            if (ex_stall) begin
                n++;
                checks++;
                if ({EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write} !== 4'b0 ||
                    EX_MEM_rd !== rd_before) begin
                    errors++;
                    $display("FAIL %s_bubble: ctrl=%b%b%b%b rd=%0d want 0000 rd=%0d", nm,
                             EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read,
                             EX_MEM_mem_write, EX_MEM_rd, rd_before);
                end
            end
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL %s_stall_len: got %0d want 33", nm, n);
        end
        tick();
        checks++;
        if (EX_MEM_alu_out !== exp || EX_MEM_reg_write !== 1'b1 || EX_MEM_rd !== 5'd7) begin
            errors++;
            $display("FAIL %s_result: got %h rw=%b want %h rw=1", nm, EX_MEM_alu_out, EX_MEM_reg_write, exp);
        end
    endtask

    // consecutive calls exercise back-to-back issue straight after DONE
    task automatic test_muldiv();
        run_md(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul");
        run_md(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_md(5'd16, 32'd1234, 32'd5678, 32'd7006652, "mul_small");
        run_md(5'd18, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        run_md(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        run_md(5'd19, 32'd10, 32'd0, 32'hFFFFFFFF, "divu_zero");
        run_md(5'd21, 32'd10, 32'd0, 32'd10, "remu_zero");
        run_md(5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_md(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
        run_md(5'd19, 32'd100, 32'd7, 32'd14, "divu");
        run_md(5'd21, 32'd100, 32'd7, 32'd2, "remu");
        run_md(5'd25, 32'd100, 32'd7, 32'd0, "md_unused");
        ID_EX_valid = 1'b0;
        tick();
    endtask

    task automatic test_no_valid();
        drive(5'd16, 32'h3, 32'h3, 32'h0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
        ID_EX_valid = 1'b0;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL novalid_stall: got %b want 0", ex_stall);
        end
        tick();
        checks++;
        if ({EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write} !== 4'b0 ||
            ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL novalid_bubble: ctrl=%b%b%b%b stall=%b want 0000 0", EX_MEM_mem_to_reg,
                     EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write, ex_stall);
        end
    endtask

    task automatic test_reset_busy();
        drive(5'd0, 32'd3, 32'd4, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd16, 32'd9, 32'd9, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        checks++;
        if (ex_stall !== 1'b1 || EX_MEM_alu_out !== 32'd7) begin
            errors++;
            $display("FAIL busy_before_reset: stall=%b alu=%h want 1 00000007", ex_stall, EX_MEM_alu_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write} !== 4'b0 ||
            EX_MEM_alu_out !== 32'h0 || EX_MEM_dataB !== 32'h0 || EX_MEM_rd !== 5'd0 ||
            ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: alu=%h rd=%0d stall=%b want 0 0 0", EX_MEM_alu_out, EX_MEM_rd, ex_stall);
        end
        drive(5'd0, 32'd5, 32'd7, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (EX_MEM_alu_out !== 32'd12 || EX_MEM_reg_write !== 1'b1 || ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_add: got %h rw=%b stall=%b want 0000000c 1 0",
                     EX_MEM_alu_out, EX_MEM_reg_write, ex_stall);
        end
        ID_EX_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_alu();
        test_store();
        test_muldiv();
        test_no_valid();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
